// File: rtl/ts_record_packer.sv
// Serializes timestamp records into big-endian byte packets: a 4-byte header
// (magic, sequence, record count, pad) followed by REC_PER_PKT records.
module ts_record_packer #(
   parameter int unsigned ID_W        = 4,
   parameter int unsigned TS_W        = 64,
   parameter int unsigned REC_PER_PKT = 4,
   parameter logic [7:0]  MAGIC       = 8'h54
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ID_W-1:0] in_id,
   input  logic [TS_W-1:0] in_start_ts,
   input  logic [TS_W-1:0] in_end_ts,
   input  logic [TS_W-1:0] in_ts,
   output logic [7:0]      m_tdata,
   output logic            m_tvalid,
   input  logic            m_tready,
   output logic            m_tlast,
   output logic [7:0]      seq_num,
   output logic            busy
);

   localparam int unsigned TSB       = TS_W / 8;
   localparam int unsigned REC_BYTES = 1 + 3 * TSB;
   localparam int unsigned REC_W     = 8 * REC_BYTES;
   localparam int unsigned BIW       = $clog2(REC_BYTES);

   localparam logic [BIW-1:0] LAST_BYTE = BIW'(REC_BYTES - 1);
   localparam logic [7:0]     LAST_REC  = 8'(REC_PER_PKT - 1);
   localparam logic [7:0]     REC_CNT   = 8'(REC_PER_PKT);

   typedef enum logic [1:0] {StIdle, StHdr, StRec, StGap} state_t;

   state_t           state;
   logic             rec_full;
   logic [REC_W-1:0] rec;
   logic [1:0]       hdr_idx;
   logic [BIW-1:0]   byte_idx;
   logic [7:0]       rec_idx;

   logic             in_fire;
   logic             out_fire;
   logic             is_last_rec;
   logic [BIW-1:0]   byte_nxt;
   logic [7:0]       next_rec_byte;
   logic [7:0]       next_hdr_byte;
   logic [REC_W-1:0] new_rec;

   assign in_ready    = !rec_full && !rst;
   assign in_fire     = in_valid && in_ready;
   assign out_fire    = m_tvalid && m_tready;
   assign busy        = (state != StIdle);
   assign is_last_rec = (rec_idx == LAST_REC);
   assign byte_nxt    = byte_idx + 1'b1;
   assign new_rec     = {8'(in_id), in_start_ts, in_end_ts, in_ts};

   // Byte k of the record register, counted from the most significant end.
   always_comb begin
      next_rec_byte = '0;
      for (int k = 0; k < int'(REC_BYTES); k++) begin
         if (byte_nxt == BIW'(k)) begin
            next_rec_byte = rec[REC_W-1-8*k -: 8];
         end
      end
   end

   always_comb begin
      next_hdr_byte = 8'h00;
      unique case (hdr_idx)
         2'd0:    next_hdr_byte = seq_num;
         2'd1:    next_hdr_byte = REC_CNT;
         default: next_hdr_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         rec_full <= 1'b0;
         rec      <= '0;
         hdr_idx  <= '0;
         byte_idx <= '0;
         rec_idx  <= '0;
         seq_num  <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end else begin
         if (in_fire) begin
            rec      <= new_rec;
            rec_full <= 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (in_fire) begin
                  state    <= StHdr;
                  hdr_idx  <= '0;
                  rec_idx  <= '0;
                  m_tvalid <= 1'b1;
                  m_tdata  <= MAGIC;
                  m_tlast  <= 1'b0;
               end
            end
            StHdr: begin
               if (out_fire) begin
                  if (hdr_idx == 2'd3) begin
                     state    <= StRec;
                     byte_idx <= '0;
                     m_tdata  <= rec[REC_W-1 -: 8];
                  end else begin
                     hdr_idx <= hdr_idx + 2'd1;
                     m_tdata <= next_hdr_byte;
                  end
               end
            end
            StRec: begin
               if (out_fire) begin
                  if (byte_idx == LAST_BYTE) begin
                     rec_full <= 1'b0;
                     m_tvalid <= 1'b0;
                     m_tlast  <= 1'b0;
                     if (is_last_rec) begin
                        seq_num <= seq_num + 8'd1;
                        state   <= StIdle;
                     end else begin
                        rec_idx <= rec_idx + 8'd1;
                        state   <= StGap;
                     end
                  end else begin
                     byte_idx <= byte_nxt;
                     m_tdata  <= next_rec_byte;
                     m_tlast  <= is_last_rec && (byte_nxt == LAST_BYTE);
                  end
               end
            end
            StGap: begin
               // Record byte 0 comes straight from the record being latched now.
               if (in_fire) begin
                  state    <= StRec;
                  byte_idx <= '0;
                  m_tvalid <= 1'b1;
                  m_tdata  <= 8'(in_id);
                  m_tlast  <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   stall_stable_a: assert property (@(posedge clk) disable iff (rst)
      (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast)));

endmodule
